// File: rtl/multdiv_wb_ctrl.sv
// Multiply/divide writeback controller: launches the unit, waits for its result and
// arbitrates the register-file port against the pipeline. Optional RUN timeout: MDV_TIMEOUT_EN.
module multdiv_wb_ctrl #(
  parameter int TIMEOUT_CYCLES = 48
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_div,
  input  logic [4:0]  dest,
  input  logic        mdv_ready,
  input  logic [31:0] mdv_result,
  input  logic        mdv_exception,
  input  logic        wb_ctrl,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        busy,
  output logic        rf_we,
  output logic [4:0]  rf_reg,
  output logic [31:0] rf_data
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state_q, state_d;
  logic        div_q, div_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d;
  logic        mult_q, mult_d;
  logic        divp_q, divp_d;

  // Result available to commit this cycle, from the unit or from the latches
  logic        fin;
  logic [31:0] fin_res;
  logic        fin_exc;
  logic        fin_tmo;
  logic        ctl_wr;

`ifdef MDV_TIMEOUT_EN
  logic [5:0]  cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    dest_d  = dest_q;
    res_d   = res_q;
    exc_d   = exc_q;
    mult_d  = 1'b0;
    divp_d  = 1'b0;
    fin     = 1'b0;
    fin_res = res_q;
    fin_exc = exc_q;
    fin_tmo = 1'b0;
    ctl_wr  = 1'b0;
`ifdef MDV_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          div_d   = is_div;
          dest_d  = dest;
          mult_d  = !is_div;
          divp_d  = is_div;
`ifdef MDV_TIMEOUT_EN
          cnt_d   = 6'd0;
          tmo_d   = 1'b0;
`endif
        end
      end
      RUN: begin
`ifdef MDV_TIMEOUT_EN
        cnt_d = cnt_q + 6'd1;
`endif
        if (mdv_ready) begin
          fin     = 1'b1;
          fin_res = mdv_result;
          fin_exc = mdv_exception;
        end
`ifdef MDV_TIMEOUT_EN
        else if (cnt_q == 6'(TIMEOUT_CYCLES - 1)) begin
          fin     = 1'b1;
          fin_res = 32'd7;
          fin_exc = 1'b0;
          fin_tmo = 1'b1;
        end
`endif
        if (fin) begin
          if (wb_ctrl) begin
            // Pipeline owns the port; park the outcome until it lets go
            state_d = HOLD;
            res_d   = fin_res;
            exc_d   = fin_exc;
`ifdef MDV_TIMEOUT_EN
            tmo_d   = fin_tmo;
`endif
          end else begin
            ctl_wr  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        fin = 1'b1;
`ifdef MDV_TIMEOUT_EN
        fin_tmo = tmo_q;
`endif
        if (!wb_ctrl) begin
          ctl_wr  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rf_we   = wb_ctrl;
    rf_reg  = wb_reg;
    rf_data = wb_data;
    if (ctl_wr) begin
      if (fin_tmo) begin
        rf_we   = 1'b1;
        rf_reg  = 5'd30;
        rf_data = 32'd7;
      end else if (fin_exc) begin
        rf_we   = 1'b1;
        rf_reg  = 5'd30;
        rf_data = div_q ? 32'd5 : 32'd4;
      end else begin
        rf_we   = (dest_q != 5'd0);
        rf_reg  = dest_q;
        rf_data = fin_res;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= 1'b0;
      dest_q  <= 5'd0;
      res_q   <= 32'd0;
      exc_q   <= 1'b0;
      mult_q  <= 1'b0;
      divp_q  <= 1'b0;
`ifdef MDV_TIMEOUT_EN
      cnt_q   <= 6'd0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      dest_q  <= dest_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      mult_q  <= mult_d;
      divp_q  <= divp_d;
`ifdef MDV_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign ctrl_MULT = mult_q;
  assign ctrl_DIV  = divp_q;
  assign busy      = (state_q != IDLE);
  assign stall     = start | (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_wb_ctrl.sv
// Directed + randomized bench for multdiv_wb_ctrl; expectations come from a
// per-operation model of when and what the controller must write.
module tb_multdiv_wb_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, is_div, mdv_ready, mdv_exception, wb_ctrl;
  logic [4:0]  dest, wb_reg;
  logic [31:0] mdv_result, wb_data;
  logic        ctrl_MULT, ctrl_DIV, stall, busy, rf_we;
  logic [4:0]  rf_reg;
  logic [31:0] rf_data;

  int n_chk  = 0;
  int n_fail = 0;

  multdiv_wb_ctrl #(.TIMEOUT_CYCLES(48)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .is_div(is_div), .dest(dest),
    .mdv_ready(mdv_ready), .mdv_result(mdv_result), .mdv_exception(mdv_exception),
    .wb_ctrl(wb_ctrl), .wb_reg(wb_reg), .wb_data(wb_data),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .stall(stall), .busy(busy),
    .rf_we(rf_we), .rf_reg(rf_reg), .rf_data(rf_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Controller not writing: port mirrors the pipeline request
  task automatic chk_pass(input string tag);
    chk({tag, ".we"},   32'(rf_we),  32'(wb_ctrl));
    chk({tag, ".reg"},  32'(rf_reg), 32'(wb_reg));
    chk({tag, ".data"}, rf_data,     wb_data);
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
    chk({tag, ".we"},   32'(rf_we),  32'(we));
    chk({tag, ".reg"},  32'(rf_reg), 32'(r));
    chk({tag, ".data"}, rf_data,     d);
  endtask

  task automatic drive_idle();
    start = 0; is_div = 0; dest = 0; mdv_ready = 0; mdv_result = 0;
    mdv_exception = 0; wb_ctrl = 0; wb_reg = 0; wb_data = 0;
  endtask

  task automatic rand_wb(input logic en);
    wb_ctrl = en; wb_reg = 5'($urandom); wb_data = $urandom;
  endtask

  // One operation: start at cycle 0, ready at cycle lat, pipeline holds the
  // port for nwb cycles from lat, so the commit lands on cycle lat+nwb.
  task automatic run_op(input string tag, input logic div, input logic [4:0] d, input int lat,
                        input logic [31:0] res, input logic exc, input int nwb, input logic [4:0] wreg);
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    if (exc) begin
      exp_we = 1; exp_reg = 5'd30; exp_data = div ? 32'd5 : 32'd4;
    end else begin
      exp_we = (d != 0); exp_reg = d; exp_data = res;
    end
    @(negedge clock);
    start = 1; is_div = div; dest = d; mdv_ready = 0; rand_wb(1'($urandom));
    #1;
    chk({tag, ".c0.stall"}, 32'(stall), 1);
    chk({tag, ".c0.busy"},  32'(busy), 0);
    chk({tag, ".c0.mul"},   32'(ctrl_MULT), 0);
    chk({tag, ".c0.div"},   32'(ctrl_DIV), 0);
    chk_pass({tag, ".c0"});
    for (int c = 1; c <= lat + nwb; c++) begin
      @(negedge clock);
      start = 1'($urandom); is_div = ~div; dest = 5'($urandom);
      mdv_ready = (c == lat);
      mdv_result = (c == lat) ? res : $urandom;
      mdv_exception = (c == lat) ? exc : 1'($urandom);
      if (c >= lat) begin
        rand_wb(c < lat + nwb);
        if (c < lat + nwb) wb_reg = wreg;
      end else rand_wb(1'($urandom));
      #1;
      chk({tag, ".run.busy"},  32'(busy), 1);
      chk({tag, ".run.stall"}, 32'(stall), 1);
      chk({tag, ".run.mul"},   32'(ctrl_MULT), 32'(c == 1 && !div));
      chk({tag, ".run.div"},   32'(ctrl_DIV),  32'(c == 1 && div));
      if (c == lat + nwb) chk_wr({tag, ".commit"}, exp_we, exp_reg, exp_data);
      else chk_pass({tag, ".run"});
    end
    @(negedge clock);
    drive_idle();
    #1;
    chk({tag, ".after.stall"}, 32'(stall), 0);
    chk({tag, ".after.busy"},  32'(busy), 0);
    chk_pass({tag, ".after"});
  endtask

  initial begin
    drive_idle();
    reset_n = 0;
    #12;
    chk("rst.busy",  32'(busy), 0);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.mul",   32'(ctrl_MULT), 0);
    chk("rst.div",   32'(ctrl_DIV), 0);
    @(negedge clock);
    reset_n = 1;

    // Stray ready in IDLE must not do anything
    @(negedge clock);
    mdv_ready = 1; mdv_result = 32'hDEAD; rand_wb(1);
    #1;
    chk_pass("idle_ready");
    chk("idle_ready.busy", 32'(busy), 0);
    @(negedge clock);
    drive_idle();
    #1;
    chk("idle_ready.busy2", 32'(busy), 0);
    chk("idle_ready.mul",   32'(ctrl_MULT), 0);

    run_op("mul7",     0, 5'd7, 17, 32'h2A,   0, 0, 5'd0);
    run_op("divexc",   1, 5'd3, 5,  $urandom, 1, 0, 5'd0);
    run_op("collide",  0, 5'd12, 4, $urandom, 0, 2, 5'd9);
    run_op("dest0",    0, 5'd0, 3,  32'hFFFF, 0, 0, 5'd0);
    run_op("minlat",   1, 5'd21, 2, $urandom, 0, 0, 5'd0);
    run_op("mulexc_h", 0, 5'd0, 6,  $urandom, 1, 3, 5'd4);

    for (int i = 0; i < 30; i++) begin
      run_op("rand", 1'($urandom), 5'($urandom), 2 + int'($urandom_range(0, 18)),
             $urandom, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), 5'($urandom));
    end

    // Reset 5 cycles into RUN discards the operation
    @(negedge clock);
    start = 1; is_div = 0; dest = 5'd11;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      start = 0;
    end
    reset_n = 0;
    #1;
    chk("rstrun.busy", 32'(busy), 0);
    chk("rstrun.mul",  32'(ctrl_MULT), 0);
    chk("rstrun.stall", 32'(stall), 0);
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    mdv_ready = 1; mdv_result = 32'h1234; wb_ctrl = 0;
    #1;
    chk("rstrun.we",    32'(rf_we), 0);
    chk("rstrun.busy2", 32'(busy), 0);
    @(negedge clock);
    drive_idle();
    #1;
    chk("rstrun.busy3", 32'(busy), 0);
    chk("rstrun.mul2",  32'(ctrl_MULT), 0);
    chk("rstrun.div2",  32'(ctrl_DIV), 0);

    // No ready at all
    @(negedge clock);
    start = 1; is_div = 1; dest = 5'd5;
`ifdef MDV_TIMEOUT_EN
    for (int c = 1; c <= 48; c++) begin
      @(negedge clock);
      start = 0;
      #1;
      if (c < 48) chk("tmo.busy", 32'(busy), 1);
      else chk_wr("tmo.commit", 1'b1, 5'd30, 32'd7);
    end
    @(negedge clock);
    #1;
    chk("tmo.after.busy", 32'(busy), 0);
`else
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      start = 0;
      #1;
      chk("hang.busy", 32'(busy), 1);
    end
    @(negedge clock);
    mdv_ready = 1; mdv_result = 32'hCAFE;
    #1;
    chk_wr("hang.commit", 1'b1, 5'd5, 32'hCAFE);
    @(negedge clock);
    drive_idle();
    #1;
    chk("hang.after.busy", 32'(busy), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
